// File: rtl/param_alu_proc.sv
// Multi-cycle memory-to-memory ALU processor sharing one single-port memory through a req/rdy handshake.
// state | meaning: FETCH read instr at PC | RD_A read mem[A] | RD_B read mem[B] | WRITE store result to mem[A] | HALT done
module param_alu_proc #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int PROG_LEN = 2**ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_memData,
    input  logic              i_memRdy,
    output logic              o_memReq,
    output logic              o_memWrEnable,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memData,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_retired,
    output logic              o_halted
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_RD_A  = 3'd1;
    localparam logic [2:0] S_RD_B  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam int                SH_W    = $clog2(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
    localparam logic [DATA_W-1:0] W_LIMIT = DATA_W'(DATA_W);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              retired_q, retired_d;

    logic [3:0]        op;
    logic [ADDR_W-1:0] a_fld, b_fld;
    logic [DATA_W-1:0] opb_eff, result;
    logic [SH_W-1:0]   shamt;
    logic              shift_big;

    assign op        = instr_q[2*ADDR_W+3 -: 4];
    assign a_fld     = instr_q[2*ADDR_W-1 -: ADDR_W];
    assign b_fld     = instr_q[ADDR_W-1:0];
    assign opb_eff   = op[3] ? {{(DATA_W-ADDR_W){1'b0}}, b_fld} : opb_q;
    assign shamt     = opb_eff[SH_W-1:0];
    assign shift_big = (opb_eff >= W_LIMIT);

    // Shift amounts of DATA_W or more saturate instead of relying on operator semantics.
    always_comb begin
        result = '0;
        case (op[2:0])
            3'd0: result = opa_q + opb_eff;
            3'd1: result = opa_q - opb_eff;
            3'd2: result = shift_big ? {DATA_W{opa_q[DATA_W-1]}} : $unsigned($signed(opa_q) >>> shamt);
            3'd3: result = shift_big ? '0 : (opa_q >> shamt);
            3'd4: result = shift_big ? '0 : (opa_q << shamt);
            3'd5: result = opa_q & opb_eff;
            3'd6: result = opa_q | opb_eff;
            default: result = opa_q ^ opb_eff;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        retired_d = 1'b0;
        case (state_q)
            S_FETCH: if (i_memRdy) begin
                instr_d = i_memData;
                state_d = S_RD_A;
            end
            S_RD_A: if (i_memRdy) begin
                opa_d   = i_memData;
                state_d = op[3] ? S_WRITE : S_RD_B;
            end
            S_RD_B: if (i_memRdy) begin
                opb_d   = i_memData;
                state_d = S_WRITE;
            end
            S_WRITE: if (i_memRdy) begin
                retired_d = 1'b1;
                if (pc_q == LAST_PC) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            instr_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        o_memAddr = '0;
        case (state_q)
            S_FETCH: o_memAddr = pc_q;
            S_RD_A:  o_memAddr = a_fld;
            S_RD_B:  o_memAddr = b_fld;
            S_WRITE: o_memAddr = a_fld;
            default: o_memAddr = '0;
        endcase
    end

    assign o_memReq      = (state_q != S_HALT);
    assign o_memWrEnable = (state_q == S_WRITE);
    assign o_memData     = (state_q == S_WRITE) ? result : '0;
    assign o_pc          = pc_q;
    assign o_retired     = retired_q;
    assign o_halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_param_alu_proc.sv
// Bench for param_alu_proc: directed programs plus random whole-program runs against an instruction-level model.
module tb_param_alu_proc;
    localparam int DW = 16;
    localparam int AW = 6;
    localparam int PL = 64;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic [DW-1:0] mem_rdata, junk;
    logic          req, we, retired, halted;
    logic [AW-1:0] addr, pc;
    logic [DW-1:0] wdata;

    logic [DW-1:0] mem     [PL];
    logic [DW-1:0] ref_mem [PL];
    int n_cmp = 0, n_fail = 0;
    int cyc, wr_count, ret_count, rdy_mode, phase, model_cycles;
    bit rd3_seen;
    int t_addr [4] = '{0, 10, 11, 10};

    always #5 clk = ~clk;

    assign mem_rdata = (req && !we && rdy) ? mem[addr] : junk;

    param_alu_proc #(.DATA_W(DW), .ADDR_W(AW), .PROG_LEN(PL)) dut (
        .i_clk(clk), .i_rst(rst), .i_memData(mem_rdata), .i_memRdy(rdy),
        .o_memReq(req), .o_memWrEnable(we), .o_memAddr(addr), .o_memData(wdata),
        .o_pc(pc), .o_retired(retired), .o_halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: memory model commits an accepted write, then inputs are updated 1 time unit later.
    task automatic tick();
        logic          do_wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        do_wr = req && we && rdy;
        wa    = addr;
        wd    = wdata;
        if (req && !we && rdy && addr == 6'd3) rd3_seen = 1'b1;
        @(posedge clk);
        if (do_wr) begin
            mem[wa] = wd;
            wr_count++;
        end
        #1;
        cyc++;
        if (retired === 1'b1) ret_count++;
        case (rdy_mode)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom_range(0, 1));
            2: begin rdy = (phase == 3); phase = (phase + 1) % 4; end
            default: ;
        endcase
        junk = DW'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0; wr_count = 0; ret_count = 0; rd3_seen = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < PL; i++) mem[i] = '0;
    endtask

    task automatic wait_retire(input int budget);
        while (retired !== 1'b1 && cyc < budget) tick();
        check("retire_timeout", {31'd0, retired}, 32'd1);
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sh, sa;
        logic [DW-1:0] r;
        sh = int'(b);
        case (op[2:0])
            3'd0: r = DW'(int'(a) + int'(b));
            3'd1: r = DW'(int'(a) - int'(b));
            3'd2: begin
                if (sh >= DW) r = {DW{a[DW-1]}};
                else begin
                    sa = a[DW-1] ? int'(a) - 65536 : int'(a);
                    for (int k = 0; k < sh; k++) sa = (sa - (sa & 1)) / 2;
                    r = DW'(sa);
                end
            end
            3'd3: r = (sh >= DW) ? '0 : DW'(int'(a) / (1 << sh));
            3'd4: r = (sh >= DW) ? '0 : DW'(int'(a) * (1 << sh));
            3'd5: r = a & b;
            3'd6: r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Executes the whole program instruction by instruction on ref_mem; code and data share the array.
    task automatic run_model(output int cycles);
        cycles = 0;
        for (int p = 0; p < PL; p++) begin
            logic [DW-1:0] ins, a, b;
            logic [3:0]    op;
            int            fa, fb;
            ins = ref_mem[p];
            op  = ins[15:12];
            fa  = int'(ins[11:6]);
            fb  = int'(ins[5:0]);
            a   = ref_mem[fa];
            b   = op[3] ? DW'(fb) : ref_mem[fb];
            ref_mem[fa] = ref_alu(op, a, b);
            cycles += op[3] ? 3 : 4;
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rdy_mode = 0; phase = 0; junk = '0;
        cyc = 0; wr_count = 0; ret_count = 0; rd3_seen = 1'b0;
        clear_mem();
        do_reset();
        check("rst_req", {31'd0, req}, 32'd1);
        check("rst_addr", {26'd0, addr}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_wdata", {16'd0, wdata}, 32'd0);
        check("rst_pc", {26'd0, pc}, 32'd0);
        check("rst_retired", {31'd0, retired}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        // Register ADD, no wait states: exact access sequence.
        clear_mem(); mem[0] = 16'h028B; mem[10] = 16'h7FFF; mem[11] = 16'h0002;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            check("add_addr", {26'd0, addr}, 32'(t_addr[c]));
            check("add_we", {31'd0, we}, (c == 3) ? 32'd1 : 32'd0);
            check("add_req", {31'd0, req}, 32'd1);
            check("add_wdata", {16'd0, wdata}, (c == 3) ? 32'h8001 : 32'd0);
            check("add_noret", {31'd0, retired}, 32'd0);
            tick();
        end
        check("add_retired", {31'd0, retired}, 32'd1);
        check("add_pc", {26'd0, pc}, 32'd1);
        check("add_mem10", {16'd0, mem[10]}, 32'h8001);
        check("add_wrcount", 32'(wr_count), 32'd1);
        check("add_fetch1", {26'd0, addr}, 32'd1);

        // SUBi: three cycles, B is never read as an address.
        clear_mem(); mem[0] = 16'h9143; mem[5] = 16'h0001;
        do_reset();
        wait_retire(20);
        check("subi_cycles", 32'(cyc), 32'd3);
        check("subi_mem5", {16'd0, mem[5]}, 32'hFFFE);
        check("subi_no_rd3", {31'd0, rd3_seen}, 32'd0);

        // Shift saturation for SRA and SRL with amount 20.
        clear_mem(); mem[0] = 16'h21C8; mem[7] = 16'h8000; mem[8] = 16'd20;
        do_reset();
        wait_retire(20);
        check("sra_cycles", 32'(cyc), 32'd4);
        check("sra_sat", {16'd0, mem[7]}, 32'hFFFF);
        clear_mem(); mem[0] = 16'h31C8; mem[7] = 16'h8000; mem[8] = 16'd20;
        do_reset();
        wait_retire(20);
        check("srl_sat", {16'd0, mem[7]}, 32'h0000);

        // Three wait cycles in every state: outputs must hold steady.
        clear_mem(); mem[0] = 16'h028B; mem[10] = 16'h7FFF; mem[11] = 16'h0002;
        rdy_mode = 2; phase = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            check("wait_addr", {26'd0, addr}, 32'(t_addr[c/4]));
            check("wait_we", {31'd0, we}, (c/4 == 3) ? 32'd1 : 32'd0);
            check("wait_req", {31'd0, req}, 32'd1);
            check("wait_wdata", {16'd0, wdata}, (c/4 == 3) ? 32'h8001 : 32'd0);
            tick();
        end
        check("wait_retired", {31'd0, retired}, 32'd1);
        check("wait_retcount", 32'(ret_count), 32'd1);
        check("wait_mem10", {16'd0, mem[10]}, 32'h8001);

        // Reset while a write is pending and not acked.
        clear_mem(); mem[0] = 16'h028B; mem[10] = 16'h7FFF; mem[11] = 16'h0002;
        rdy_mode = 0;
        do_reset();
        tick(); tick(); tick();
        check("rstw_in_write", {31'd0, we}, 32'd1);
        rdy_mode = 3; rdy = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_nowrite", 32'(wr_count), 32'd0);
        check("rstw_mem10", {16'd0, mem[10]}, 32'h7FFF);
        check("rstw_addr", {26'd0, addr}, 32'd0);
        check("rstw_req", {31'd0, req}, 32'd1);
        check("rstw_we", {31'd0, we}, 32'd0);
        check("rstw_pc", {26'd0, pc}, 32'd0);
        check("rstw_retired", {31'd0, retired}, 32'd0);

        // Random full programs run to halt, with and without random wait states.
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < PL; i++) begin
                mem[i]     = DW'($urandom);
                ref_mem[i] = mem[i];
            end
            run_model(model_cycles);
            rdy_mode = (round == 0) ? 0 : 1;
            rdy = 1'b1;
            do_reset();
            while (halted !== 1'b1 && cyc < 4000) tick();
            check("rnd_halt_timeout", {31'd0, halted}, 32'd1);
            if (round == 0) check("rnd_cycles", 32'(cyc), 32'(model_cycles));
            check("rnd_writes", 32'(wr_count), 32'(PL));
            check("rnd_retires", 32'(ret_count), 32'(PL));
            check("rnd_pc", {26'd0, pc}, 32'(PL - 1));
            check("rnd_req", {31'd0, req}, 32'd0);
            for (int i = 0; i < PL; i++) check("rnd_mem", {16'd0, mem[i]}, {16'd0, ref_mem[i]});
            rdy_mode = 1;
            for (int k = 0; k < 6; k++) tick();
            check("rnd_stay_halted", {31'd0, halted}, 32'd1);
            check("rnd_pc_frozen", {26'd0, pc}, 32'(PL - 1));
            check("rnd_no_more_writes", 32'(wr_count), 32'(PL));
        end

        rdy_mode = 0;
        do_reset();
        check("rsth_halted", {31'd0, halted}, 32'd0);
        check("rsth_pc", {26'd0, pc}, 32'd0);
        check("rsth_req", {31'd0, req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
